// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-write store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
    logic             valid;
  } sb_entry_t;

  typedef enum logic [1:0] {PORT_IDLE, PORT_WR, PORT_RD} port_sel_t;

endpackage

// File: rtl/sb_addr_match.sv
// Word-address comparator across all buffer entries; reports any hit and the
// index of the youngest matching entry.
module sb_addr_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [PTR_W-1:0] head,
  input  logic [AW-1:0]    ld_addr,
  output logic             hit,
  output logic [PTR_W-1:0] hit_idx
);

  logic [PTR_W-1:0] idx;
  logic [DEPTH-1:0] unused_bits;

  // Valid entries are contiguous from head, so scanning oldest to youngest
  // and letting later matches overwrite leaves the youngest hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (entries[idx].valid && (entries[idx].addr[AW-1:2] == ld_addr[AW-1:2])) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_unused
    assign unused_bits[g] = ^{entries[g].data, entries[g].addr[1:0], ld_addr[1:0]};
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and data memory; loads take the port
// ahead of queued stores. Define STORE_BUF_FWD_EN to forward hazard loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_req,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  input  logic                       ld_req,
  input  logic [AW-1:0]              ld_addr,
  input  logic                       drain,
  output logic                       stall,
  output logic                       ld_valid,
  output logic [DW-1:0]              ld_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  output logic                       mem_write,
  output logic                       mem_read,
  input  logic [DW-1:0]              mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  sb_entry_t        entries  [DEPTH];
  logic [PTR_W-1:0] head, tail, hit_idx;
  logic             full, prio_wr, hit;
  logic             st_push, pop, ld_accept, ld_fwd, ld_read;
  logic [DW-1:0]    fwd_data;
  port_sel_t        port;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign entries[g] = '{addr: ent_addr[g], data: ent_data[g], valid: ent_valid[g]};
  end

  sb_addr_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
    .entries (entries),
    .head    (head),
    .ld_addr (ld_addr),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign prio_wr = (drain || full) && !empty;
  assign st_push = st_req && !full;

`ifdef STORE_BUF_FWD_EN
  // A forwarded load never needs the port, so it cannot lose arbitration.
  assign ld_fwd    = ld_req && hit;
  assign ld_accept = ld_req && (hit || !prio_wr);
  assign fwd_data  = ent_data[hit_idx];
`else
  logic unused_idx;
  assign unused_idx = ^hit_idx;
  assign ld_fwd     = 1'b0;
  assign ld_accept  = ld_req && !hit && !prio_wr;
  assign fwd_data   = '0;
`endif

  assign ld_read = ld_accept && !ld_fwd;

  always_comb begin
    port = PORT_IDLE;
    if (prio_wr)      port = PORT_WR;
    else if (ld_read) port = PORT_RD;
    else if (!empty)  port = PORT_WR;
  end

  assign pop       = (port == PORT_WR);
  assign mem_write = !rst && (port == PORT_WR);
  assign mem_read  = !rst && (port == PORT_RD);
  assign mem_addr  = (port == PORT_RD) ? ld_addr : ent_addr[head];
  assign mem_wdata = ent_data[head];
  assign stall     = !rst && ((st_req && full) || (ld_req && !ld_accept));

  // Control state: pointers, occupancy, entry valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (st_push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      case ({st_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Entry payload carries no reset; valid bits qualify it
  always_ff @(posedge clk) begin
    if (st_push) begin
      ent_addr[tail] <= st_addr;
      ent_data[tail] <= st_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_valid <= 1'b0;
      ld_data  <= '0;
    end else begin
      ld_valid <= ld_accept;
      if (ld_accept) ld_data <= ld_fwd ? fwd_data : mem_rdata;
    end
  end

  a_no_st_ld: assert property (@(posedge clk) disable iff (rst) !(st_req && ld_req));

endmodule
